// File: rtl/tm_qm_queue_depth.sv
// Per-queue depth tracker: depth = enq_cnt - deq_cnt held in duplicated 1r1w RAMs.
// Optional global high-watermark enabled by TM_QM_DEPTH_WATERMARK_EN.
module tm_qm_queue_depth #(
  parameter int QB = 4
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef TM_QM_DEPTH_WATERMARK_EN
  input  logic          wm_clr,
  output logic [QB:0]   wm_depth,
  output logic [QB-1:0] wm_qid,
`endif
  input  logic          depth_enq_req,
  input  logic [QB-1:0] depth_enq_qid,
  input  logic          depth_deq_req,
  input  logic [QB-1:0] depth_deq_qid,
  output logic          init_done,
  output logic          depth_enq_ack,
  output logic          depth_enq_to_empty,
  output logic [QB:0]   depth_enq_depth,
  output logic          depth_deq_ack,
  output logic          depth_deq_from_emptyp2,
  output logic [QB:0]   depth_deq_depth,
  output logic          err_underflow,
  output logic          err_req_in_init
);
  localparam int NQ = 2**QB;
  localparam logic [QB:0] CNT_ONE = (QB+1)'(1);
  localparam logic [QB:0] CNT_TWO = (QB+1)'(2);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e        state_q, state_d;
  logic [QB-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + QB'(1);
      if (init_addr_q == {QB{1'b1}}) state_d = ST_RUN;
    end
  end

  assign init_done = (state_q == ST_RUN);

  logic          s1_enq_v_q, s1_deq_v_q;
  logic [QB-1:0] s1_enq_qid_q, s1_deq_qid_q;
  logic          enq_fw_v_q, deq_fw_v_q;
  logic [QB-1:0] enq_fw_qid_q, deq_fw_qid_q;
  logic [QB:0]   enq_fw_cnt_q, deq_fw_cnt_q;

  logic          enq_we, deq_we, deq_ok;
  logic [QB-1:0] enq_wa, deq_wa;
  logic [QB:0]   enq_wd, deq_wd;
  logic [QB:0]   e_enq_cnt, e_deq_cnt, d_enq_cnt, d_deq_cnt, e_old, d_old;
  logic [QB-1:0] rd_addr [2];

  assign rd_addr[0] = depth_enq_qid;
  assign rd_addr[1] = depth_deq_qid;

  // Copy 0 is read by the enqueue path, copy 1 by the dequeue path; both copies take every write.
  for (genvar gi = 0; gi < 2; gi++) begin : g_copy
    logic [QB:0] enq_mem [NQ];
    logic [QB:0] deq_mem [NQ];
    logic [QB:0] enq_rd_q, deq_rd_q;
    always_ff @(posedge clk) begin
      if (enq_we) enq_mem[enq_wa] <= enq_wd;
      if (deq_we) deq_mem[deq_wa] <= deq_wd;
      enq_rd_q <= enq_mem[rd_addr[gi]];
      deq_rd_q <= deq_mem[rd_addr[gi]];
    end
  end

  // RAM reads return pre-write data for last cycle's update, so that update is forwarded here.
  always_comb begin
    e_enq_cnt = g_copy[0].enq_rd_q;
    if (enq_fw_v_q && enq_fw_qid_q == s1_enq_qid_q) e_enq_cnt = enq_fw_cnt_q;
    e_deq_cnt = g_copy[0].deq_rd_q;
    if (deq_fw_v_q && deq_fw_qid_q == s1_enq_qid_q) e_deq_cnt = deq_fw_cnt_q;
    d_enq_cnt = g_copy[1].enq_rd_q;
    if (enq_fw_v_q && enq_fw_qid_q == s1_deq_qid_q) d_enq_cnt = enq_fw_cnt_q;
    if (s1_enq_v_q && s1_enq_qid_q == s1_deq_qid_q) d_enq_cnt = e_enq_cnt + CNT_ONE;
    d_deq_cnt = g_copy[1].deq_rd_q;
    if (deq_fw_v_q && deq_fw_qid_q == s1_deq_qid_q) d_deq_cnt = deq_fw_cnt_q;
  end

  assign e_old  = e_enq_cnt - e_deq_cnt;
  assign d_old  = d_enq_cnt - d_deq_cnt;
  assign deq_ok = s1_deq_v_q && (d_old != '0);

  assign enq_we = init_done ? s1_enq_v_q   : 1'b1;
  assign enq_wa = init_done ? s1_enq_qid_q : init_addr_q;
  assign enq_wd = init_done ? e_enq_cnt + CNT_ONE : '0;
  assign deq_we = init_done ? deq_ok       : 1'b1;
  assign deq_wa = init_done ? s1_deq_qid_q : init_addr_q;
  assign deq_wd = init_done ? d_deq_cnt + CNT_ONE : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_enq_v_q             <= 1'b0;
      s1_deq_v_q             <= 1'b0;
      s1_enq_qid_q           <= '0;
      s1_deq_qid_q           <= '0;
      enq_fw_v_q             <= 1'b0;
      deq_fw_v_q             <= 1'b0;
      enq_fw_qid_q           <= '0;
      deq_fw_qid_q           <= '0;
      enq_fw_cnt_q           <= '0;
      deq_fw_cnt_q           <= '0;
      depth_enq_ack          <= 1'b0;
      depth_enq_to_empty     <= 1'b0;
      depth_enq_depth        <= '0;
      depth_deq_ack          <= 1'b0;
      depth_deq_from_emptyp2 <= 1'b0;
      depth_deq_depth        <= '0;
      err_underflow          <= 1'b0;
      err_req_in_init        <= 1'b0;
    end else begin
      s1_enq_v_q             <= depth_enq_req && init_done;
      s1_deq_v_q             <= depth_deq_req && init_done;
      s1_enq_qid_q           <= depth_enq_qid;
      s1_deq_qid_q           <= depth_deq_qid;
      enq_fw_v_q             <= s1_enq_v_q;
      deq_fw_v_q             <= deq_ok;
      enq_fw_qid_q           <= s1_enq_qid_q;
      deq_fw_qid_q           <= s1_deq_qid_q;
      enq_fw_cnt_q           <= e_enq_cnt + CNT_ONE;
      deq_fw_cnt_q           <= d_deq_cnt + CNT_ONE;
      depth_enq_ack          <= s1_enq_v_q;
      depth_enq_to_empty     <= s1_enq_v_q && (e_old == '0);
      depth_enq_depth        <= s1_enq_v_q ? e_old + CNT_ONE : '0;
      depth_deq_ack          <= s1_deq_v_q;
      depth_deq_from_emptyp2 <= deq_ok && (d_old >= CNT_TWO);
      depth_deq_depth        <= deq_ok ? d_old - CNT_ONE : '0;
      err_underflow          <= s1_deq_v_q && !deq_ok;
      err_req_in_init        <= (depth_enq_req || depth_deq_req) && !init_done;
    end
  end

`ifdef TM_QM_DEPTH_WATERMARK_EN
  logic [QB:0]   wm_depth_q;
  logic [QB-1:0] wm_qid_q, ack_qid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_depth_q <= '0;
      wm_qid_q   <= '0;
      ack_qid_q  <= '0;
    end else begin
      ack_qid_q <= s1_enq_qid_q;
      if (wm_clr) begin
        wm_depth_q <= '0;
        wm_qid_q   <= '0;
      end else if (depth_enq_ack && depth_enq_depth > wm_depth_q) begin
        wm_depth_q <= depth_enq_depth;
        wm_qid_q   <= ack_qid_q;
      end
    end
  end

  assign wm_depth = wm_depth_q;
  assign wm_qid   = wm_qid_q;
`endif
endmodule

// File: tb/tb_tm_qm_queue_depth.sv
// Bench for tm_qm_queue_depth: hand-written vector table plus randomised traffic,
// expected acks queued at drive time and compared two cycles later.
`timescale 1ns/1ps
module tb_tm_qm_queue_depth;
  localparam int QB = 4;
  localparam int NQ = 2**QB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          depth_enq_req = 1'b0, depth_deq_req = 1'b0;
  logic [QB-1:0] depth_enq_qid = '0, depth_deq_qid = '0;
  logic          init_done, depth_enq_ack, depth_enq_to_empty, depth_deq_ack;
  logic          depth_deq_from_emptyp2, err_underflow, err_req_in_init;
  logic [QB:0]   depth_enq_depth, depth_deq_depth;
`ifdef TM_QM_DEPTH_WATERMARK_EN
  logic          wm_clr = 1'b0;
  logic [QB:0]   wm_depth;
  logic [QB-1:0] wm_qid;
`endif

  always #5 clk = ~clk;

  tm_qm_queue_depth #(.QB(QB)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef TM_QM_DEPTH_WATERMARK_EN
    .wm_clr(wm_clr), .wm_depth(wm_depth), .wm_qid(wm_qid),
`endif
    .depth_enq_req(depth_enq_req), .depth_enq_qid(depth_enq_qid),
    .depth_deq_req(depth_deq_req), .depth_deq_qid(depth_deq_qid),
    .init_done(init_done), .depth_enq_ack(depth_enq_ack),
    .depth_enq_to_empty(depth_enq_to_empty), .depth_enq_depth(depth_enq_depth),
    .depth_deq_ack(depth_deq_ack), .depth_deq_from_emptyp2(depth_deq_from_emptyp2),
    .depth_deq_depth(depth_deq_depth), .err_underflow(err_underflow),
    .err_req_in_init(err_req_in_init)
  );

  typedef struct {
    logic ev; logic [QB-1:0] eq; logic dv; logic [QB-1:0] dq;
    logic e_ack; logic e_te; logic [QB:0] e_d;
    logic d_ack; logic d_fe2; logic [QB:0] d_d; logic uf;
  } vec_t;

  vec_t  sb_q[$];
  string tag_q[$];
  vec_t  tbl[19];
  int    model_depth[NQ];
  int    n_vec = 0, n_miss = 0;

  function automatic vec_t mk(int ev, int eq, int dv, int dq, int ea, int te, int ed,
                              int da, int fe, int dd, int uf);
    vec_t r;
    r.ev = 1'(ev); r.eq = QB'(eq); r.dv = 1'(dv); r.dq = QB'(dq);
    r.e_ack = 1'(ea); r.e_te = 1'(te); r.e_d = (QB+1)'(ed);
    r.d_ack = 1'(da); r.d_fe2 = 1'(fe); r.d_d = (QB+1)'(dd); r.uf = 1'(uf);
    return r;
  endfunction

  // Behavioural depth model: enqueue takes effect before a same-cycle dequeue.
  function automatic vec_t model(vec_t v);
    vec_t r;
    r = mk(v.ev, v.eq, v.dv, v.dq, v.ev, 0, 0, v.dv, 0, 0, 0);
    if (v.ev) begin
      r.e_te = (model_depth[v.eq] == 0);
      model_depth[v.eq]++;
      r.e_d = (QB+1)'(model_depth[v.eq]);
    end
    if (v.dv) begin
      if (model_depth[v.dq] == 0) r.uf = 1'b1;
      else begin
        r.d_fe2 = (model_depth[v.dq] >= 2);
        model_depth[v.dq]--;
        r.d_d = (QB+1)'(model_depth[v.dq]);
      end
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else $display("ok   %s: %0d", name, act);
  endtask

  task automatic check_out(vec_t e, string tag);
    n_vec++;
    if ({depth_enq_ack, depth_enq_to_empty, depth_enq_depth, depth_deq_ack, depth_deq_from_emptyp2,
         depth_deq_depth, err_underflow, err_req_in_init} !==
        {e.e_ack, e.e_te, e.e_d, e.d_ack, e.d_fe2, e.d_d, e.uf, 1'b0}) begin
      n_miss++;
      $display("FAIL %s: got enq ack=%b te=%b d=%0d deq ack=%b fe2=%b d=%0d uf=%b ini=%b; want enq ack=%b te=%b d=%0d deq ack=%b fe2=%b d=%0d uf=%b ini=0",
               tag, depth_enq_ack, depth_enq_to_empty, depth_enq_depth, depth_deq_ack,
               depth_deq_from_emptyp2, depth_deq_depth, err_underflow, err_req_in_init,
               e.e_ack, e.e_te, e.e_d, e.d_ack, e.d_fe2, e.d_d, e.uf);
    end else
      $display("ok   %s: enq ack=%b te=%b d=%0d deq ack=%b fe2=%b d=%0d uf=%b", tag,
               depth_enq_ack, depth_enq_to_empty, depth_enq_depth, depth_deq_ack,
               depth_deq_from_emptyp2, depth_deq_depth, err_underflow);
  endtask

  // Drive one cycle of requests; the response to the previous cycle is compared after the edge.
  task automatic step(vec_t e, string tag);
    depth_enq_req = e.ev; depth_enq_qid = e.eq;
    depth_deq_req = e.dv; depth_deq_qid = e.dq;
    sb_q.push_back(e); tag_q.push_back(tag);
    @(posedge clk); #1;
    depth_enq_req = 1'b0; depth_deq_req = 1'b0;
    if (sb_q.size() >= 2) check_out(sb_q.pop_front(), tag_q.pop_front());
  endtask

  task automatic flush();
    @(posedge clk); #1;
    while (sb_q.size() > 0) check_out(sb_q.pop_front(), tag_q.pop_front());
  endtask

  task automatic wait_init(string name);
    int c;
    c = 0;
    for (int k = 1; k <= 40 && !init_done; k++) begin
      depth_enq_req = (k == 3); depth_enq_qid = QB'(5);
      @(posedge clk); #1;
      depth_enq_req = 1'b0;
      c = k;
      if (!init_done) chk({name, "_init_ack"}, int'(depth_enq_ack), 0);
      if (k == 3 || k == 4) chk({name, "_err_req_in_init"}, int'(err_req_in_init), int'(k == 3));
    end
    chk({name, "_init_cycles"}, init_done ? c : -1, NQ);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(1,3,0,0, 1,1,1, 0,0,0, 0);
    tbl[1]  = mk(1,3,0,0, 1,0,2, 0,0,0, 0);
    tbl[2]  = mk(1,3,0,0, 1,0,3, 0,0,0, 0);
    tbl[3]  = mk(0,0,1,3, 0,0,0, 1,1,2, 0);
    tbl[4]  = mk(0,0,1,3, 0,0,0, 1,1,1, 0);
    tbl[5]  = mk(0,0,1,3, 0,0,0, 1,0,0, 0);
    tbl[6]  = mk(1,7,1,7, 1,1,1, 1,0,0, 0);
    tbl[7]  = mk(0,0,1,9, 0,0,0, 1,0,0, 1);
    tbl[8]  = mk(1,9,0,0, 1,1,1, 0,0,0, 0);
    tbl[9]  = mk(1,2,1,9, 1,1,1, 1,0,0, 0);
    tbl[10] = mk(1,9,1,2, 1,1,1, 1,0,0, 0);
    tbl[11] = mk(0,0,0,0, 0,0,0, 0,0,0, 0);
    tbl[12] = mk(1,4,0,0, 1,1,1, 0,0,0, 0);
    tbl[13] = mk(0,0,1,4, 0,0,0, 1,0,0, 0);
    tbl[14] = mk(1,4,1,4, 1,1,1, 1,0,0, 0);
    tbl[15] = mk(1,4,0,0, 1,1,1, 0,0,0, 0);
    tbl[16] = mk(1,4,1,4, 1,0,2, 1,1,1, 0);
    tbl[17] = mk(0,0,1,4, 0,0,0, 1,0,0, 0);
    tbl[18] = mk(1,5,0,0, 1,1,1, 0,0,0, 0);
    for (int q = 0; q < NQ; q++) model_depth[q] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_init_done", int'(init_done), 0);
    check_out(mk(0,0,0,0, 0,0,0, 0,0,0, 0), "reset_outputs");
    @(negedge clk) reset_n = 1'b1;
    wait_init("boot");

    for (int i = 0; i < 19; i++) begin
      v = model(tbl[i]);
      step(tbl[i], $sformatf("tbl%0d", i));
    end
    flush();

`ifdef TM_QM_DEPTH_WATERMARK_EN
    chk("wm_depth_table", int'(wm_depth), 3);
    chk("wm_qid_table", int'(wm_qid), 3);
    wm_clr = 1'b1; @(posedge clk); #1; wm_clr = 1'b0;
    chk("wm_depth_clr0", int'(wm_depth), 0);
`endif

    for (int k = 0; k < 2**(QB+1) + 2; k++) begin
      v = model(mk(1,1,0,0, 0,0,0, 0,0,0, 0));
      step(mk(1,1,0,0, 1,1,1, 0,0,0, 0), $sformatf("wrap_enq%0d", k));
      v = model(mk(0,0,1,1, 0,0,0, 0,0,0, 0));
      step(mk(0,0,1,1, 0,0,0, 1,0,0, 0), $sformatf("wrap_deq%0d", k));
    end
    flush();

`ifdef TM_QM_DEPTH_WATERMARK_EN
    chk("wm_depth_wrap", int'(wm_depth), 1);
    chk("wm_qid_wrap", int'(wm_qid), 1);
    wm_clr = 1'b1; @(posedge clk); #1; wm_clr = 1'b0;
    chk("wm_depth_clr1", int'(wm_depth), 0);
`endif

    for (int k = 0; k < 300; k++) begin
      v = mk(0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), 0,0,0, 0,0,0, 0);
      v.ev = ($urandom_range(0, 1) == 1) && (model_depth[v.eq] < NQ - 1);
      step(model(v), $sformatf("rand%0d", k));
    end
    flush();

    step(mk(1,3,0,0, 1,(model_depth[3] == 0),model_depth[3]+1, 0,0,0, 0), "pre_rst_a");
    step(mk(1,3,0,0, 1,0,model_depth[3]+2, 0,0,0, 0), "pre_rst_b");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ack", int'(depth_enq_ack), 0);
    chk("async_rst_init_done", int'(init_done), 0);
    sb_q.delete(); tag_q.delete();
    for (int q = 0; q < NQ; q++) model_depth[q] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    wait_init("rerun");
    step(mk(1,3,0,0, 1,1,1, 0,0,0, 0), "post_rst_enq3");
    flush();
    chk("init_done_held", int'(init_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
